// File: rtl/coffee_vending_fsm_if.sv
// -----------------------------------------------------------------------------
// coffee_vending_fsm_if
//
// Purpose:
//   Bundles the coin-acceptor inputs and the dispenser/change-hopper outputs
//   of the coffee vending controller into one connection.
//
// Signals (credit and change in 50-unit steps):
//   in50          coin side -> controller  level, one 50-unit coin per sampled-high edge
//   in100         coin side -> controller  level, one 100-unit coin per sampled-high edge
//   give_coffee   controller -> dispenser  one-cycle dispense pulse
//   change_units  controller -> hopper     change to return, valid with give_coffee
//   credit        controller -> display    accumulated credit
//   cups_served   controller -> display    dispense counter (VEND_CUP_COUNTER_EN only)
//
// Modports:
//   master  coin-acceptor / environment side (drives the coin inputs)
//   slave   vending controller side (drives the dispense outputs)
//
// Optional feature macro: VEND_CUP_COUNTER_EN
// -----------------------------------------------------------------------------
interface coffee_vending_fsm_if #(
    parameter int CW = 4
);
    logic          in50;
    logic          in100;
    logic          give_coffee;
    logic [CW-1:0] change_units;
    logic [CW-1:0] credit;
`ifdef VEND_CUP_COUNTER_EN
    logic [15:0]   cups_served;

    modport master (
        output in50,
        output in100,
        input  give_coffee,
        input  change_units,
        input  credit,
        input  cups_served
    );

    modport slave (
        input  in50,
        input  in100,
        output give_coffee,
        output change_units,
        output credit,
        output cups_served
    );
`else
    modport master (
        output in50,
        output in100,
        input  give_coffee,
        input  change_units,
        input  credit
    );

    modport slave (
        input  in50,
        input  in100,
        output give_coffee,
        output change_units,
        output credit
    );
`endif
endinterface

// File: rtl/coffee_vending_fsm.sv
// -----------------------------------------------------------------------------
// coffee_vending_fsm
//
// Purpose:
//   Coin-operated coffee vending controller. Accumulates 50- and 100-unit
//   coins; when the credit reaches the price it issues a one-cycle dispense
//   pulse together with the change owed, and clears the credit.
//   All outputs come straight from registers.
//
// Parameters:
//   PRICE_UNITS  coffee price in 50-unit steps (legal 2..15, default 3 = 150)
//   CW           width of credit/change counters; must hold PRICE_UNITS+2
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   asynchronous active-low reset
//   bus    slave modport of coffee_vending_fsm_if
//            in50, in100                  coin inputs (level, sampled each edge)
//            give_coffee                  one-cycle dispense pulse
//            change_units                 change in 50-unit steps, valid with pulse
//            credit                       accumulated credit
//            cups_served                  dispense counter (optional feature)
//
// Optional feature macro: VEND_CUP_COUNTER_EN
//   Defined     -> 16-bit wrapping cups_served counter, cleared by reset.
//   Not defined -> counter and its port are absent.
// -----------------------------------------------------------------------------
module coffee_vending_fsm #(
    parameter int PRICE_UNITS = 3,
    parameter int CW          = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    coffee_vending_fsm_if.slave  bus
);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter sanity checks
    // -------------------------------------------------------------------------
    generate
        if (PRICE_UNITS < 2 || PRICE_UNITS > 15) begin : g_bad_price
            $error("coffee_vending_fsm: PRICE_UNITS must be in 2..15");
        end
        if ((1 << CW) <= (PRICE_UNITS + 2)) begin : g_bad_cw
            $error("coffee_vending_fsm: CW too narrow to hold PRICE_UNITS+2");
        end
    endgenerate

    // Price at the widths used for comparison (one extra bit) and subtraction.
    localparam logic [CW:0]   L_PRICE_CMP = (CW+1)'(PRICE_UNITS);
    localparam logic [CW-1:0] L_PRICE_SUB = CW'(PRICE_UNITS);

    // -------------------------------------------------------------------------
    // State encoding
    //   ST_EMPTY    no credit held (S0)
    //   ST_PARTIAL  some credit held, below the price (S50, S100, ...)
    //   ST_VEND     the last edge reached the price; give_coffee is this state.
    // The exact credit amount lives in r_credit; the enum tracks the phase.
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_VEND    = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_credit;
    logic [CW-1:0] w_credit_next;
    logic [CW-1:0] r_change;
    logic [CW-1:0] w_change_next;

    // Coin value this cycle: in50 = 1 step, in100 = 2 steps, both = 3 steps.
    logic [1:0]    w_coin;
    // Credit plus coin, one bit wider so it can never wrap.
    logic [CW:0]   w_sum;
    // Overpayment; at most 2 steps, so CW bits are always enough.
    logic [CW-1:0] w_overpay;
    logic          w_reach_price;

    assign w_coin        = {bus.in100, bus.in50};
    assign w_sum         = {1'b0, r_credit} + {{(CW-1){1'b0}}, w_coin};
    assign w_reach_price = (w_sum >= L_PRICE_CMP);
    assign w_overpay     = w_sum[CW-1:0] - L_PRICE_SUB;

    // -------------------------------------------------------------------------
    // State / datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_EMPTY;
            r_credit <= '0;
            r_change <= '0;
        end else begin
            r_state  <= w_state_next;
            r_credit <= w_credit_next;
            r_change <= w_change_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // Every state behaves the same way with respect to coins: the decision
    // depends only on the running sum, so no branch on r_state is needed.
    // In particular ST_VEND always leaves (credit was cleared when it was
    // entered), which guarantees give_coffee is a one-cycle pulse unless
    // another full price arrives on the very next edge.
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next  = ST_EMPTY;
        w_credit_next = '0;
        w_change_next = '0;

        if (w_reach_price) begin
            w_state_next  = ST_VEND;
            w_change_next = w_overpay;
        end else if (w_sum != '0) begin
            w_state_next  = ST_PARTIAL;
            w_credit_next = w_sum[CW-1:0];
        end
    end

    // -------------------------------------------------------------------------
    // Outputs (all driven from registers)
    // -------------------------------------------------------------------------
    assign bus.give_coffee  = (r_state == ST_VEND);
    assign bus.change_units = r_change;
    assign bus.credit       = r_credit;

`ifdef VEND_CUP_COUNTER_EN
    // Counts together with the dispense pulse so cups_served already includes
    // the cup whose give_coffee is currently high. Wraps naturally at 16 bits.
    logic [15:0] r_cups_served;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cups_served <= '0;
        end else if (w_state_next == ST_VEND) begin
            r_cups_served <= r_cups_served + 16'd1;
        end
    end

    assign bus.cups_served = r_cups_served;
`endif

endmodule

// File: tb/tb_coffee_vending_fsm.sv
// -----------------------------------------------------------------------------
// tb_coffee_vending_fsm
//
// Directed bench for coffee_vending_fsm at the default price (3 steps = 150).
// Inputs are changed 1 time unit after a rising edge; outputs are sampled at
// that same point, i.e. away from the active edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_coffee_vending_fsm;

    localparam int CW = 4;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    coffee_vending_fsm_if #(.CW(CW)) bus ();

    coffee_vending_fsm #(
        .PRICE_UNITS (3),
        .CW          (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of coins, then sample just after the edge.
    task automatic step(input logic c50, input logic c100);
        bus.in50  = c50;
        bus.in100 = c100;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input int exp_credit,
                              input logic exp_give, input int exp_change);
        $display("%0t %s: in50=%0b in100=%0b credit=%0d give_coffee=%0b change_units=%0d",
                 $time, tag, bus.in50, bus.in100, bus.credit, bus.give_coffee,
                 bus.change_units);
        checks++;
        assert (bus.credit === CW'(exp_credit)) else begin
            errors++;
            $error("FAIL %s credit: got %0d expected %0d", tag, bus.credit, exp_credit);
        end
        checks++;
        assert (bus.give_coffee === exp_give) else begin
            errors++;
            $error("FAIL %s give_coffee: got %0b expected %0b", tag, bus.give_coffee, exp_give);
        end
        checks++;
        assert (bus.change_units === CW'(exp_change)) else begin
            errors++;
            $error("FAIL %s change_units: got %0d expected %0d", tag, bus.change_units, exp_change);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b0;
        bus.in50  = 1'b0;
        bus.in100 = 1'b1;

        // Reset held with in100 high: nothing accumulates.
        step(1'b0, 1'b1); expect_out("rst_hold0", 0, 1'b0, 0);
        step(1'b0, 1'b1); expect_out("rst_hold1", 0, 1'b0, 0);
        step(1'b0, 1'b1); expect_out("rst_hold2", 0, 1'b0, 0);

        // Release, gain credit, then clear asynchronously mid-cycle.
        bus.in100 = 1'b0;
        reset     = 1'b1;
        step(1'b1, 1'b0); expect_out("pre_async", 1, 1'b0, 0);
        bus.in50 = 1'b0;
        #2 reset = 1'b0;
        #1 expect_out("async_clear", 0, 1'b0, 0);
        #1 reset = 1'b1;
        step(1'b0, 1'b0); expect_out("after_async", 0, 1'b0, 0);

        // Exact payment: 50 + 50 + 50.
        step(1'b1, 1'b0); expect_out("exact_c1", 1, 1'b0, 0);
        step(1'b1, 1'b0); expect_out("exact_c2", 2, 1'b0, 0);
        step(1'b1, 1'b0); expect_out("exact_vend", 0, 1'b1, 0);
        step(1'b0, 1'b0); expect_out("exact_idle", 0, 1'b0, 0);

        // Overpay: 50 then held 100.
        step(1'b1, 1'b0); expect_out("over_c1", 1, 1'b0, 0);
        step(1'b0, 1'b1); expect_out("over_vend0", 0, 1'b1, 0);
        step(1'b0, 1'b1); expect_out("over_c2a", 2, 1'b0, 0);
        step(1'b0, 1'b1); expect_out("over_vend1", 0, 1'b1, 1);
        step(1'b0, 1'b1); expect_out("over_c2b", 2, 1'b0, 0);
        step(1'b0, 1'b1); expect_out("over_vend2", 0, 1'b1, 1);
        step(1'b0, 1'b0); expect_out("over_idle", 0, 1'b0, 0);

        // Simultaneous coins.
        step(1'b1, 1'b1); expect_out("both_from0", 0, 1'b1, 0);
        step(1'b0, 1'b1); expect_out("both_c2", 2, 1'b0, 0);
        step(1'b1, 1'b1); expect_out("both_from2", 0, 1'b1, 2);
        step(1'b0, 1'b0); expect_out("both_idle", 0, 1'b0, 0);

        // Idle for five cycles, then 100 followed by 50.
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0); expect_out($sformatf("idle%0d", i), 0, 1'b0, 0);
        end
        step(1'b0, 1'b1); expect_out("mix_c2", 2, 1'b0, 0);
        step(1'b1, 1'b0); expect_out("mix_vend", 0, 1'b1, 0);

        // Reset during accumulation discards credit without change.
        step(1'b0, 1'b1); expect_out("acc_c2", 2, 1'b0, 0);
        bus.in100 = 1'b0;
        #2 reset = 1'b0;
        #1 expect_out("acc_rst", 0, 1'b0, 0);
        step(1'b1, 1'b0); expect_out("acc_rst_held", 0, 1'b0, 0);
        bus.in50 = 1'b0;
        #2 reset = 1'b1;
        @(posedge clk); #1;
        step(1'b1, 1'b0); expect_out("acc_after", 1, 1'b0, 0);
        step(1'b0, 1'b0); expect_out("acc_hold", 1, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
